// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin arbiter: one port owns the shared frame path from sop to eop.
// Optional watchdog abort of hung frames is compiled in with `define FRAME_TIMEOUT_EN.
module frame_rr_arbiter #(
    parameter int unsigned N_PORT      = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_PORT-1:0] i_req,
    input  logic [N_PORT-1:0] i_sop,
    input  logic [N_PORT-1:0] i_eop,
    output logic [N_PORT-1:0] o_gnt,
    output logic [ID_W-1:0]   o_gnt_id,
    output logic              o_busy,
    output logic [15:0]       o_frame_cnt,
    output logic              o_timeout
);

    if (N_PORT < 2 || N_PORT > 16 || ID_W != $clog2(N_PORT) || TIMEOUT_CYC < 2) begin : g_param_err
        $error("frame_rr_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t            state_q, state_nxt;
    logic [N_PORT-1:0] gnt_q, gnt_nxt;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_nxt;
    logic [ID_W-1:0]   ptr_q, ptr_nxt;
    logic              busy_q, busy_nxt;
    logic [15:0]       cnt_q, cnt_nxt;
    logic              timeout_q, timeout_nxt;

    logic              found;
    logic [ID_W-1:0]   sel;
    logic [ID_W:0]     pos;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_q, wd_nxt;
`endif

    // First requester strictly after the pointer, scanning cyclically.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < N_PORT; k++) begin
            pos = {1'b0, ptr_q} + (ID_W + 1)'(k + 1);
            if (pos >= (ID_W + 1)'(N_PORT)) begin
                pos = pos - (ID_W + 1)'(N_PORT);
            end
            if (!found && i_req[pos[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = pos[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state_q;
        gnt_nxt     = gnt_q;
        gnt_id_nxt  = gnt_id_q;
        ptr_nxt     = ptr_q;
        cnt_nxt     = cnt_q;
        timeout_nxt = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        wd_nxt      = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_nxt      = GRANT;
                    gnt_nxt        = '0;
                    gnt_nxt[sel]   = 1'b1;
                    gnt_id_nxt     = sel;
`ifdef FRAME_TIMEOUT_EN
                    wd_nxt         = '0;
`endif
                end
            end
            GRANT: begin
                if (i_sop[gnt_id_q]) begin
                    if (i_eop[gnt_id_q]) begin
                        state_nxt = REL;
                        gnt_nxt   = '0;
                        cnt_nxt   = cnt_q + 16'd1;
                        ptr_nxt   = gnt_id_q;
                    end else begin
                        state_nxt = BUSY;
                    end
                end else if (!i_req[gnt_id_q]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (i_eop[gnt_id_q]) begin
                    state_nxt = REL;
                    gnt_nxt   = '0;
                    cnt_nxt   = cnt_q + 16'd1;
                    ptr_nxt   = gnt_id_q;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef FRAME_TIMEOUT_EN
        // A normal sop/eop/req-drop transition wins over the watchdog in the same cycle.
        if ((state_q == GRANT || state_q == BUSY) && (state_nxt == GRANT || state_nxt == BUSY)) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                state_nxt   = IDLE;
                gnt_nxt     = '0;
                ptr_nxt     = gnt_id_q;
                timeout_nxt = 1'b1;
            end else begin
                wd_nxt = wd_q + 1'b1;
            end
        end
`endif
        busy_nxt = (state_nxt == GRANT) || (state_nxt == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= ID_W'(N_PORT - 1);
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            gnt_q     <= gnt_nxt;
            gnt_id_q  <= gnt_id_nxt;
            ptr_q     <= ptr_nxt;
            busy_q    <= busy_nxt;
            cnt_q     <= cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_nxt;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_gnt       = gnt_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_busy      = busy_q;
    assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Self-checking bench for frame_rr_arbiter; grant order predicted by a bench-side round-robin model.
// Build with +define+FRAME_TIMEOUT_EN to exercise the watchdog path instead of the hold path.
module tb_frame_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_req, i_sop, i_eop;
    logic [3:0]  o_gnt;
    logic [1:0]  o_gnt_id;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];
    int model_ptr;
    int mcnt;

    frame_rr_arbiter #(
        .N_PORT      (4),
        .ID_W        (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_sop       (i_sop),
        .i_eop       (i_eop),
        .o_gnt       (o_gnt),
        .o_gnt_id    (o_gnt_id),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int p;
            p = (ptr + k) % 4;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_gnt != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '0;
        i_sop = '0;
        i_eop = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_ptr = 3;
        mcnt      = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = '0;
        i_sop = '0;
        i_eop = '0;
        @(negedge clk);
        checks++;
        if ({o_gnt, o_gnt_id, o_busy, o_frame_cnt, o_timeout} !== 24'h0) begin
            errors++;
            $display("FAIL reset_values: got gnt=%b id=%0d busy=%b cnt=%0d to=%b, want all zero",
                     o_gnt, o_gnt_id, o_busy, o_frame_cnt, o_timeout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0000 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got gnt=%b busy=%b, want 0000/0", o_gnt, o_busy);
        end
        model_ptr = 3;
        mcnt      = 0;
    endtask

    task automatic test_drop();
        bit ok;
        int e;
        i_req = 4'b0001;
        exp_q.push_back(rr_pick(i_req, model_ptr));
        wait_gnt(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o_gnt !== (4'b0001 << e) || o_gnt_id !== 2'(e)) begin
            errors++;
            $display("FAIL drop_first_grant: got gnt=%b id=%0d, want port %0d", o_gnt, o_gnt_id, e);
        end
        i_req = 4'b0000;
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0000 || o_busy !== 1'b0 || o_frame_cnt !== 16'(mcnt)) begin
            errors++;
            $display("FAIL drop_release: got gnt=%b busy=%b cnt=%0d, want 0000/0/%0d",
                     o_gnt, o_busy, o_frame_cnt, mcnt);
        end
        i_req = 4'b1001;
        exp_q.push_back(rr_pick(i_req, model_ptr));
        wait_gnt(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o_gnt !== (4'b0001 << e) || o_gnt_id !== 2'(e)) begin
            errors++;
            $display("FAIL drop_keeps_priority: got gnt=%b id=%0d, want port %0d", o_gnt, o_gnt_id, e);
        end
        i_sop = 4'b0001 << e;
        i_eop = 4'b0001 << e;
        i_req = 4'b0000;
        @(negedge clk);
        i_sop = '0;
        i_eop = '0;
        mcnt++;
        model_ptr = e;
        checks++;
        if (o_gnt !== 4'b0000 || o_frame_cnt !== 16'(mcnt)) begin
            errors++;
            $display("FAIL drop_then_frame: got gnt=%b cnt=%0d, want 0000/%0d", o_gnt, o_frame_cnt, mcnt);
        end
        @(negedge clk);
    endtask

    task automatic test_rr_order();
        bit ok;
        int e;
        int p;
        do_reset();
        i_req = 4'b1111;
        p = model_ptr;
        for (int f = 0; f < 5; f++) begin
            e = rr_pick(i_req, p);
            exp_q.push_back(e);
            p = e;
        end
        for (int f = 0; f < 5; f++) begin
            wait_gnt(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || o_gnt !== (4'b0001 << e) || o_gnt_id !== 2'(e)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got gnt=%b id=%0d, want port %0d", f, o_gnt, o_gnt_id, e);
            end
            for (int b = 0; b < 8; b++) begin
                i_sop = '0;
                i_eop = '0;
                i_sop[e] = (b == 0);
                i_eop[e] = (b == 7);
                if (b == 7 && f == 4) i_req = 4'b0000;
                @(negedge clk);
                if (b == 3) begin
                    checks++;
                    if (o_busy !== 1'b1 || o_gnt !== (4'b0001 << e)) begin
                        errors++;
                        $display("FAIL rr_hold[%0d]: got gnt=%b busy=%b, want port %0d held", f, o_gnt, o_busy, e);
                    end
                end
            end
            i_sop = '0;
            i_eop = '0;
            mcnt++;
            model_ptr = e;
            checks++;
            if (o_gnt !== 4'b0000 || o_busy !== 1'b0 || o_frame_cnt !== 16'(mcnt)) begin
                errors++;
                $display("FAIL rr_release[%0d]: got gnt=%b busy=%b cnt=%0d, want 0000/0/%0d",
                         f, o_gnt, o_busy, o_frame_cnt, mcnt);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int e;
        int prev;
        i_req = 4'b0100;
        for (int f = 0; f < 4; f++) exp_q.push_back(rr_pick(i_req, 2));
        exp_q[0] = rr_pick(i_req, model_ptr);
        prev = 0;
        for (int f = 0; f < 4; f++) begin
            wait_gnt(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || o_gnt !== (4'b0001 << e)) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got gnt=%b, want port %0d", f, o_gnt, e);
            end
            if (f > 0) begin
                checks++;
                if (cyc - prev !== 3) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 3", f, cyc - prev);
                end
            end
            prev = cyc;
            i_sop = 4'b0001 << e;
            i_eop = 4'b0001 << e;
            if (f == 3) i_req = 4'b0000;
            @(negedge clk);
            i_sop = '0;
            i_eop = '0;
            mcnt++;
            model_ptr = e;
            checks++;
            if (o_gnt !== 4'b0000 || o_frame_cnt !== 16'(mcnt)) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got gnt=%b cnt=%0d, want 0000/%0d", f, o_gnt, o_frame_cnt, mcnt);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_others();
        bit ok;
        int e;
        logic [3:0] sop_seq [5];
        logic [3:0] eop_seq [5];
        sop_seq = '{4'b1001, 4'b0010, 4'b1001, 4'b0010, 4'b0001};
        eop_seq = '{4'b1001, 4'b1000, 4'b0001, 4'b0000, 4'b0010};
        i_req = 4'b0010;
        exp_q.push_back(rr_pick(i_req, model_ptr));
        wait_gnt(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o_gnt !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL ignore_grant: got gnt=%b, want port %0d", o_gnt, e);
        end
        for (int c = 0; c < 5; c++) begin
            i_sop = sop_seq[c];
            i_eop = eop_seq[c];
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (o_gnt !== (4'b0001 << e) || o_frame_cnt !== 16'(mcnt)) begin
                    errors++;
                    $display("FAIL ignore_hold[%0d]: got gnt=%b cnt=%0d, want %b/%0d",
                             c, o_gnt, o_frame_cnt, 4'b0001 << e, mcnt);
                end
            end
        end
        i_sop = '0;
        i_eop = '0;
        i_req = 4'b0000;
        mcnt++;
        model_ptr = e;
        checks++;
        if (o_gnt !== 4'b0000 || o_frame_cnt !== 16'(mcnt)) begin
            errors++;
            $display("FAIL ignore_release: got gnt=%b cnt=%0d, want 0000/%0d", o_gnt, o_frame_cnt, mcnt);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0000 || o_gnt_id !== 2'(e)) begin
            errors++;
            $display("FAIL idle_id_hold: got gnt=%b id=%0d, want 0000/%0d", o_gnt, o_gnt_id, e);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int e;
        i_req = 4'b0100;
        exp_q.push_back(rr_pick(i_req, model_ptr));
        wait_gnt(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o_gnt !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL midrst_grant: got gnt=%b, want port %0d", o_gnt, e);
        end
        i_sop = 4'b0001 << e;
        @(negedge clk);
        i_sop = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_gnt, o_gnt_id, o_busy, o_frame_cnt, o_timeout} !== 24'h0) begin
            errors++;
            $display("FAIL midrst_values: got gnt=%b id=%0d busy=%b cnt=%0d to=%b, want all zero",
                     o_gnt, o_gnt_id, o_busy, o_frame_cnt, o_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 4'b0000;
        mcnt = 0;
        model_ptr = 3;
        i_eop = 4'b0001 << e;
        @(negedge clk);
        i_eop = '0;
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0000 || o_frame_cnt !== 16'(mcnt)) begin
            errors++;
            $display("FAIL midrst_lost: got gnt=%b cnt=%0d, want 0000/%0d", o_gnt, o_frame_cnt, mcnt);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int e;
`ifdef FRAME_TIMEOUT_EN
        int k_hit;
`else
        bit saw_to;
        bit held;
`endif
        do_reset();
        i_req = 4'b0011;
        exp_q.push_back(rr_pick(i_req, model_ptr));
        wait_gnt(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || o_gnt !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL wd_grant: got gnt=%b, want port %0d", o_gnt, e);
        end
        i_sop = 4'b0001 << e;
        @(negedge clk);
        i_sop = '0;
`ifdef FRAME_TIMEOUT_EN
        k_hit = -1;
        for (int k = 1; k <= 40; k++) begin
            if (o_timeout === 1'b1) begin
                k_hit = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (k_hit !== 16) begin
            errors++;
            $display("FAIL wd_pulse_time: got %0d cycles after grant, want 16", k_hit);
        end
        checks++;
        if (o_gnt !== 4'b0000 || o_frame_cnt !== 16'(mcnt)) begin
            errors++;
            $display("FAIL wd_abort: got gnt=%b cnt=%0d, want 0000/%0d", o_gnt, o_frame_cnt, mcnt);
        end
        model_ptr = e;
        exp_q.push_back(rr_pick(i_req, model_ptr));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (o_timeout !== 1'b0 || o_gnt !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL wd_next_grant: got to=%b gnt=%b, want 0/port %0d", o_timeout, o_gnt, e);
        end
        i_req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
`else
        saw_to = 1'b0;
        held   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (o_timeout !== 1'b0) saw_to = 1'b1;
            if (o_gnt !== (4'b0001 << e)) held = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (saw_to !== 1'b0 || held !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_eop: got timeout_seen=%b held=%b, want 0/1", saw_to, held);
        end
        i_eop = 4'b0001 << e;
        i_req = 4'b0000;
        @(negedge clk);
        i_eop = '0;
        mcnt++;
        checks++;
        if (o_gnt !== 4'b0000 || o_frame_cnt !== 16'(mcnt)) begin
            errors++;
            $display("FAIL hold_release: got gnt=%b cnt=%0d, want 0000/%0d", o_gnt, o_frame_cnt, mcnt);
        end
        @(negedge clk);
`endif
    endtask

    // Bound on total run time so a stuck design cannot hang the bench.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_drop();
        test_rr_order();
        test_back_to_back();
        test_ignore_others();
        test_reset_mid_frame();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
